// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
//   state_e      : receiver FSM states
//   DefaultDataW : default number of data bits per frame
//   frame_len()  : samples per frame (start + data + optional parity + stop)
package serial_frame_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_e;

    localparam int unsigned DefaultDataW = 4;

    function automatic int unsigned frame_len(input int unsigned data_w, input bit parity_en);
        return data_w + 32'(parity_en) + 32'd2;
    endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Bundle of the serial input side and the parallel valid/ready output side of
// serial_frame_rx, plus its status pulses.
//   master : the receiver (drives out_data/out_valid/status, samples bit_en/sin/out_ready)
//   slave  : the environment (drives bit_en/sin/out_ready)
interface serial_frame_rx_if
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW
);
    logic              bit_en;
    logic              sin;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    modport master (
        input  bit_en, sin, out_ready,
        output out_data, out_valid, parity_err, frame_err, overrun, busy
    );

    modport slave (
        output bit_en, sin, out_ready,
        input  out_data, out_valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/rx_out_buf.sv
// One-word valid/ready holding register for received words.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : a good word is offered this cycle
//   load_data   : the offered word
//   out_ready   : consumer accepts the held word on this edge
//   out_data    : held word
//   out_valid   : held word not yet delivered
//   accepted    : the offered word is taken (buffer empty or draining this edge)
module rx_out_buf #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              accepted
);
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    assign accepted = load & (~valid_q | out_ready);

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (accepted) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame deserializer: LSB-first start/data/[even parity]/stop frames
// sampled on bit_en strobes, delivered through a one-word valid/ready buffer.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : serial_frame_rx_if master (bit_en, sin, out_ready in;
//              out_data, out_valid, parity_err, frame_err, overrun, busy out)
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W    = DefaultDataW,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    serial_frame_rx_if.master   bus
);
    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              load;
    logic              accepted;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        load         = 1'b0;
        if (bus.bit_en) begin
            unique case (state_q)
                StIdle: begin
                    if (!bus.sin) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                        shreg_d   = '0;
                        // Cleared so a parity-less build never sees a stale mismatch.
                        par_bad_d = 1'b0;
                    end
                end
                StData: begin
                    shreg_d   = {bus.sin, shreg_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                    if (bit_cnt_q == LastCnt) begin
                        state_d = PARITY_EN ? StParity : StStop;
                    end
                end
                StParity: begin
                    par_bad_d = ^{shreg_q, bus.sin};
                    state_d   = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    // A bad stop bit outranks a parity mismatch.
                    if (!bus.sin) begin
                        frame_err_d = 1'b1;
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign overrun_d = load & ~accepted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    rx_out_buf #(
        .DATA_W(DATA_W)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(shreg_q),
        .out_ready(bus.out_ready),
        .out_data (bus.out_data),
        .out_valid(bus.out_valid),
        .accepted (accepted)
    );

    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;
    import serial_frame_pkg::*;

    localparam int unsigned W    = 4;
    localparam bit          PE   = 1'b1;
    localparam int unsigned FLEN = frame_len(W, PE);

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    serial_frame_rx_if #(.DATA_W(W)) bus ();

    serial_frame_rx #(
        .DATA_W   (W),
        .PARITY_EN(PE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: collects samples of a frame, then judges it by arithmetic.
    logic         m_frame[$];
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_busy;
    logic         e_perr;
    logic         e_ferr;
    logic         e_ovr;

    task automatic model_reset();
        m_frame.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_busy  = 1'b0;
        e_perr  = 1'b0;
        e_ferr  = 1'b0;
        e_ovr   = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic en, input logic rdy);
        logic         good;
        logic [W-1:0] data;
        logic         par;
        logic         stop;
        good   = 1'b0;
        data   = '0;
        e_perr = 1'b0;
        e_ferr = 1'b0;
        e_ovr  = 1'b0;
        if (en) begin
            if (m_frame.size() != 0 || s == 1'b0) m_frame.push_back(s);
            if (m_frame.size() == FLEN) begin
                for (int i = 0; i < W; i++) data[i] = m_frame[1+i];
                par  = PE ? m_frame[W+1] : 1'b0;
                stop = m_frame[FLEN-1];
                if (!stop) e_ferr = 1'b1;
                else if ((($countones(data) + int'(par)) % 2) != 0) e_perr = 1'b1;
                else good = 1'b1;
                m_frame.delete();
            end
        end
        if (good && (!m_valid || rdy)) begin
            m_valid = 1'b1;
            m_data  = data;
        end else begin
            if (good) e_ovr = 1'b1;
            if (m_valid && rdy) m_valid = 1'b0;
        end
        m_busy = (m_frame.size() != 0);
    endtask

    // Drive one clock of stimulus; returns 1 time unit after the rising edge.
    task automatic step(input logic s, input logic en, input logic rdy);
        bus.sin       = s;
        bus.bit_en    = en;
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge(s, en, rdy);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic par_flip, input logic stop,
                              input logic rdy, input logic rdy_last, input logic toggle);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(d[i]);
        if (PE) bits.push_back((^d) ^ par_flip);
        bits.push_back(stop);
        for (int i = 0; i < bits.size(); i++) begin
            if (toggle) step(1'($urandom_range(1)), 1'b0, rdy);
            step(bits[i], 1'b1, (i == bits.size() - 1) ? rdy_last : rdy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.sin = 1'b1;
        bus.bit_en = 1'b0;
        bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp += 4;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid);
        end
        if (bus.out_data !== 4'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", bus.out_data);
        end
        if ({bus.parity_err, bus.frame_err, bus.overrun} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 000",
                               {bus.parity_err, bus.frame_err, bus.overrun});
        end
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_good_frame();
        send_frame(4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp += 2;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 4'hC}) begin
            n_fail++; $display("FAIL good_word: got v=%b d=%h want v=1 d=c",
                               bus.out_valid, bus.out_data);
        end
        if ({bus.parity_err, bus.frame_err, bus.overrun} !== 3'b000) begin
            n_fail++; $display("FAIL good_pulses: got %b want 000",
                               {bus.parity_err, bus.frame_err, bus.overrun});
        end
        step(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL good_drain: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_parity_err();
        send_frame(4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.parity_err, bus.frame_err, bus.overrun, bus.out_valid} !== 4'b1000) begin
            n_fail++; $display("FAIL parity_err: got perr/ferr/ovr/valid=%b want 1000",
                               {bus.parity_err, bus.frame_err, bus.overrun, bus.out_valid});
        end
        step(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if ({bus.parity_err, bus.out_valid} !== 2'b00) begin
            n_fail++; $display("FAIL parity_pulse_len: got perr/valid=%b want 00",
                               {bus.parity_err, bus.out_valid});
        end
    endtask

    task automatic test_frame_err();
        // Second pass also has bad parity: the stop error must win.
        for (int k = 0; k < 2; k++) begin
            send_frame(4'hC, 1'(k), 1'b0, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if ({bus.frame_err, bus.parity_err, bus.out_valid} !== 3'b100) begin
                n_fail++; $display("FAIL frame_err[%0d]: got ferr/perr/valid=%b want 100",
                                   k, {bus.frame_err, bus.parity_err, bus.out_valid});
            end
            send_frame(4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if ({bus.out_valid, bus.out_data, bus.frame_err} !== {1'b1, 4'h3, 1'b0}) begin
                n_fail++; $display("FAIL frame_b2b[%0d]: got v=%b d=%h ferr=%b want v=1 d=3 ferr=0",
                                   k, bus.out_valid, bus.out_data, bus.frame_err);
            end
            step(1'b1, 1'b1, 1'b1);
        end
    endtask

    task automatic test_overrun();
        send_frame(4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.overrun, bus.out_valid, bus.out_data} !== {1'b1, 1'b1, 4'hC}) begin
            n_fail++; $display("FAIL overrun: got ovr=%b v=%b d=%h want ovr=1 v=1 d=c",
                               bus.overrun, bus.out_valid, bus.out_data);
        end
        step(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.overrun, bus.out_valid, bus.out_data} !== {1'b0, 1'b1, 4'hC}) begin
            n_fail++; $display("FAIL overrun_hold: got ovr=%b v=%b d=%h want ovr=0 v=1 d=c",
                               bus.overrun, bus.out_valid, bus.out_data);
        end
        step(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL overrun_drain: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_simultaneous();
        for (int t = 0; t < 2; t++) begin
            send_frame(4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'(t));
            send_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'(t));
            n_cmp++;
            if ({bus.overrun, bus.out_valid, bus.out_data} !== {1'b0, 1'b1, 4'h3}) begin
                n_fail++; $display("FAIL simul[%0d]: got ovr=%b v=%b d=%h want ovr=0 v=1 d=3",
                                   t, bus.overrun, bus.out_valid, bus.out_data);
            end
            step(1'b1, 1'b1, 1'b1);
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL simul_drain[%0d]: got %b want 0", t, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre_busy: got %b want 1", bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({bus.busy, bus.out_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.out_data}
            !== 9'b0) begin
            n_fail++; $display("FAIL midrst: got busy/v/perr/ferr/ovr/d=%b want all 0",
                               {bus.busy, bus.out_valid, bus.parity_err, bus.frame_err,
                                bus.overrun, bus.out_data});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        send_frame(4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 4'hA}) begin
            n_fail++; $display("FAIL midrst_after: got v=%b d=%h want v=1 d=a",
                               bus.out_valid, bus.out_data);
        end
        step(1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic         stream[$];
        logic [W-1:0] d;
        logic         en;
        logic         s;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (stream.size() == 0) begin
                for (int g = 0; g < int'($urandom_range(2)); g++) stream.push_back(1'b1);
                d = W'($urandom);
                stream.push_back(1'b0);
                for (int i = 0; i < W; i++) stream.push_back(d[i]);
                if (PE) stream.push_back((^d) ^ ($urandom_range(3) == 0));
                stream.push_back($urandom_range(7) != 0);
            end
            en = ($urandom_range(3) != 0);
            s  = en ? stream.pop_front() : 1'($urandom_range(1));
            step(s, en, 1'($urandom_range(1)));
            n_cmp++;
            if ({bus.out_valid, bus.out_data, bus.parity_err, bus.frame_err, bus.overrun,
                 bus.busy} !== {m_valid, m_data, e_perr, e_ferr, e_ovr, m_busy}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got v/d/perr/ferr/ovr/busy=%b/%h/%b/%b/%b/%b want %b/%h/%b/%b/%b/%b",
                         cyc, bus.out_valid, bus.out_data, bus.parity_err, bus.frame_err,
                         bus.overrun, bus.busy, m_valid, m_data, e_perr, e_ferr, e_ovr, m_busy);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_overrun();
        test_simultaneous();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial frame deserializer that sits directly downstream of the universal shift register. It consumes the register's shift-right serial output (LSB first) and detects a start bit. It then collects DATA_W data bits and an optional even-parity bit, checks the stop bit, and presents each good word on a valid/ready parallel port backed by a one-word holding register.

## Interface
- DATA_W, 4: data bits per frame (2–16)
- PARITY_EN, 1: 1 = one even-parity bit follows data; 0 = no parity bit
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- bit_en  in  1  sample strobe; `sin` is sampled only on edges where bit_en=1
- sin  in  1  serial input; idle level 1
- out_data  out  DATA_W  received word, bit 0 = first data bit received
- out_valid  out  1  out_data holds an undelivered word
- out_ready  in  1  consumer accepts; transfer occurs on an edge with out_valid & out_ready
- parity_err  out  1  one-clock pulse: frame dropped, parity mismatch
- frame_err  out  1  one-clock pulse: frame dropped, stop bit sampled 0
- overrun  out  1  one-clock pulse: good frame dropped, holding register occupied
- busy  out  1  1 whenever state ≠ IDLE

## Operation
- States: IDLE, DATA, PARITY, STOP.
- **IDLE:**
  - A sampled `sin`=0 moves to DATA and clears bit_cnt and the shift register.
  - A sampled `sin`=1 stays in IDLE.
- **DATA:**
  - Each sample shifts `sin` into the MSB of shreg (shift right) and increments bit_cnt.
  - After the DATA_W-th sample, go to PARITY if PARITY_EN=1, else to STOP.
- **PARITY:**
  - Sample the parity bit.
  - par_bad = XOR of data bits and parity bit (even parity: 1 means mismatch).
  - Go to STOP.
- **STOP:**
  - Sample the stop bit and always return to IDLE.
  - `sin`=0: drop the frame and pulse frame_err. This takes priority over a parity error.
  - Else if par_bad: drop the frame and pulse parity_err.
  - Else the frame is good:
    - If the holding register is empty, or is being emptied this same edge (out_valid & out_ready), load out_data from shreg and set out_valid=1.
    - Otherwise drop the new word, pulse overrun, and keep the held word unchanged.
- **Holding register:**
  - out_valid clears on the transfer edge unless a new word loads on that same edge.
  - out_data is stable while out_valid=1 and out_ready=0.
- Edges with bit_en=0 leave the state, bit_cnt and shreg unchanged. The handshake and the error pulses still proceed.
- A new start bit is accepted on the first sample after STOP; no idle gap is required.
- bit_cnt width is clog2(DATA_W+1). It is never compared beyond DATA_W.

## Timing
- **Reset:**
  - Asynchronous: state=IDLE, bit_cnt=0, shreg=0.
  - Outputs: out_data=0, out_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- **Reset mid-frame:** abort immediately. No partial word and no error pulse is produced. The held word is lost.
- **Latency:**
  - out_valid and the error pulses are registered.
  - They become visible the cycle after the clock edge that sampled the stop bit.
  - Each error pulse lasts exactly one clock.
- **Frame length:**
  - With bit_en held at 1, one frame occupies 1 + DATA_W + PARITY_EN + 1 samples, i.e. 7 clocks at the defaults.
- All outputs are driven from flops; there is no combinational path from `sin`.

## Structure
- **Package `serial_frame_pkg`:**
  - state enum (IDLE, DATA, PARITY, STOP)
  - default DATA_W
  - localparam FRAME_LEN function
- **Sub-module `rx_out_buf`:**
  - one-word valid/ready holding register
  - inputs: load, load_data, out_ready
  - outputs: out_data, out_valid, accepted (the load was taken)
  - overrun = load & ~accepted
- The FSM, bit counter, shreg and parity check live in the top level.

## Test plan
All scenarios use DATA_W=4, PARITY_EN=1 and bit_en=1 unless stated.
1. **Good frame:** sin = 0,0,0,1,1,0,1 with out_ready=1 → out_data=4'hC and out_valid for 1 cycle, beginning the cycle after the 7th sample; no error pulses.
2. **Parity error:** sin = 0,1,0,1,0,1,1 (data 4'h5, parity 1) → parity_err for 1 cycle, out_valid stays 0.
3. **Frame error:** 4'hC frame with stop bit 0 → frame_err pulses, parity_err does not, out_valid=0; the next frame 4'h3 (0,1,1,0,0,0,1) is received correctly back-to-back.
4. **Overrun:**
   - Hold out_ready=0 and send 4'hC, then 4'h3.
   - Required: out_data stays 4'hC with out_valid=1, and overrun pulses once.
   - Then raise out_ready for one cycle: out_valid falls.
5. **Simultaneous events and strobe:**
   - Assert out_ready on the exact edge that samples the 4'h3 stop bit while 4'hC is held → no overrun, out_data becomes 4'h3.
   - Repeat with bit_en toggling 1/0 → identical results at half the rate.
6. **Reset mid-frame:**
   - Assert rst after 3 data bits → busy=0, out_valid=0 and all pulses 0 immediately.
   - After release, a 4'hA frame (0,0,1,0,1,0,1) yields out_data=4'hA.
